// File: rtl/pwm_scan_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_scan_pkg : states, host register map, status bits, sat add   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pwm_scan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ZERO  = 3'd1,
    SIG   = 3'd2,
    DWELL = 3'd3,
    NEXT  = 3'd4,
    STOP  = 3'd5,
    FIN   = 3'd6
  } state_t;

  localparam logic [3:0] c_reg_ctrl   = 4'd0;
  localparam logic [3:0] c_reg_zero0  = 4'd1;
  localparam logic [3:0] c_reg_sig0   = 4'd5;
  localparam logic [3:0] c_reg_step0  = 4'd9;
  localparam logic [3:0] c_reg_nstep0 = 4'd11;
  localparam logic [3:0] c_reg_dwell0 = 4'd13;
  localparam logic [3:0] c_reg_status = 4'd15;

  localparam int c_st_busy  = 0;
  localparam int c_st_done  = 1;
  localparam int c_st_abort = 2;
  localparam int c_st_err   = 3;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [15:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {17'd0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_scan_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_scan_if : host byte-register bus plus pwm register port      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface pwm_scan_if;
  logic [7:0]  addr;
  logic [7:0]  data_in;
  logic        we;
  logic [7:0]  data_out;
  logic [7:0]  pwm_addr;
  logic [7:0]  pwm_data;
  logic        pwm_we;
  logic [31:0] pwm_data32;
  logic        pwm_we32;

  modport slave (
    input  addr, data_in, we,
    output data_out, pwm_addr, pwm_data, pwm_we, pwm_data32, pwm_we32
  );

  modport master (
    output addr, data_in, we,
    input  data_out, pwm_addr, pwm_data, pwm_we, pwm_data32, pwm_we32
  );
endinterface
`default_nettype wire

// File: rtl/pwm_scan_regs.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_scan_regs : host register file, start/abort strobes, read mux|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pwm_scan_regs
  import pwm_scan_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h50
) (
  input  logic        clk,
  input  logic        res,
  input  logic [7:0]  addr,
  input  logic [7:0]  data_in,
  input  logic        we,
  input  logic        busy,
  input  logic [7:0]  status,
  output logic [7:0]  data_out,
  output logic [31:0] zero,
  output logic [31:0] sig_start,
  output logic [15:0] step,
  output logic [15:0] n_steps,
  output logic [15:0] dwell,
  output logic        start,
  output logic        abort
);

  logic [8:0]  w_diff;
  logic        w_hit;
  logic [3:0]  w_off;
  logic        w_wr;
  logic [7:0]  w_rd;

  logic [31:0] r_zero;
  logic [31:0] r_sig_start;
  logic [15:0] r_step;
  logic [15:0] r_n_steps;
  logic [15:0] r_dwell;
  logic        r_start;
  logic        r_abort;
  logic [7:0]  r_data_out;

  // A borrow out of the subtraction means the address lies below the window.
  assign w_diff = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign w_hit  = ~w_diff[8] && (w_diff[7:4] == 4'd0);
  assign w_off  = w_diff[3:0];
  assign w_wr   = we && w_hit;

  always_comb begin
    w_rd = 8'h00;
    if (w_hit) begin
      case (w_off)
        c_reg_zero0:          w_rd = r_zero[7:0];
        c_reg_zero0 + 4'd1:   w_rd = r_zero[15:8];
        c_reg_zero0 + 4'd2:   w_rd = r_zero[23:16];
        c_reg_zero0 + 4'd3:   w_rd = r_zero[31:24];
        c_reg_sig0:           w_rd = r_sig_start[7:0];
        c_reg_sig0 + 4'd1:    w_rd = r_sig_start[15:8];
        c_reg_sig0 + 4'd2:    w_rd = r_sig_start[23:16];
        c_reg_sig0 + 4'd3:    w_rd = r_sig_start[31:24];
        c_reg_step0:          w_rd = r_step[7:0];
        c_reg_step0 + 4'd1:   w_rd = r_step[15:8];
        c_reg_nstep0:         w_rd = r_n_steps[7:0];
        c_reg_nstep0 + 4'd1:  w_rd = r_n_steps[15:8];
        c_reg_dwell0:         w_rd = r_dwell[7:0];
        c_reg_dwell0 + 4'd1:  w_rd = r_dwell[15:8];
        c_reg_status:         w_rd = status;
        default:              w_rd = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_zero      <= 32'd0;
      r_sig_start <= 32'd0;
      r_step      <= 16'd0;
      r_n_steps   <= 16'd0;
      r_dwell     <= 16'd0;
      r_start     <= 1'b0;
      r_abort     <= 1'b0;
      r_data_out  <= 8'h00;
    end else begin
      r_start    <= w_wr && (w_off == c_reg_ctrl) && data_in[0];
      r_abort    <= w_wr && (w_off == c_reg_ctrl) && data_in[1];
      r_data_out <= w_rd;
      if (w_wr && !busy) begin
        case (w_off)
          c_reg_zero0:          r_zero[7:0]        <= data_in;
          c_reg_zero0 + 4'd1:   r_zero[15:8]       <= data_in;
          c_reg_zero0 + 4'd2:   r_zero[23:16]      <= data_in;
          c_reg_zero0 + 4'd3:   r_zero[31:24]      <= data_in;
          c_reg_sig0:           r_sig_start[7:0]   <= data_in;
          c_reg_sig0 + 4'd1:    r_sig_start[15:8]  <= data_in;
          c_reg_sig0 + 4'd2:    r_sig_start[23:16] <= data_in;
          c_reg_sig0 + 4'd3:    r_sig_start[31:24] <= data_in;
          c_reg_step0:          r_step[7:0]        <= data_in;
          c_reg_step0 + 4'd1:   r_step[15:8]       <= data_in;
          c_reg_nstep0:         r_n_steps[7:0]     <= data_in;
          c_reg_nstep0 + 4'd1:  r_n_steps[15:8]    <= data_in;
          c_reg_dwell0:         r_dwell[7:0]       <= data_in;
          c_reg_dwell0 + 4'd1:  r_dwell[15:8]      <= data_in;
          default: ;
        endcase
      end
    end
  end

  assign data_out  = r_data_out;
  assign zero      = r_zero;
  assign sig_start = r_sig_start;
  assign step      = r_step;
  assign n_steps   = r_n_steps;
  assign dwell     = r_dwell;
  assign start     = r_start;
  assign abort     = r_abort;

endmodule
`default_nettype wire

// File: rtl/pwm_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_scan_ctrl : pwm pulse-width scan sequencer (FSM + counters)  |
// | Optional dwell watchdog: define PWM_SCAN_TIMEOUT_EN. Rev 1.0     |
// +------------------------------------------------------------------+
module pwm_scan_ctrl
  import pwm_scan_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR       = 8'h50,
  parameter logic [7:0]  PWM_SIG_ADDR    = 8'h42,
  parameter logic [7:0]  PWM_ZERO32_ADDR = 8'h46,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1000000
) (
  input  logic       clk,
  input  logic       res,
  pwm_scan_if.slave  bus,
  input  logic       pwm_out,
  output logic       bus_own,
  output logic       step_strb,
  output logic       done
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_byte;
  logic [15:0] r_idx;
  logic [15:0] r_cnt;
  logic [31:0] r_cur_sig;
  logic        r_pwm_s1;
  logic        r_pwm_s2;
  logic        r_abort_pend;
  logic        r_done_flag;
  logic        r_aborted;
  logic        r_err;

  logic [31:0] w_zero;
  logic [31:0] w_sig_start;
  logic [15:0] w_step;
  logic [15:0] w_n_steps;
  logic [15:0] w_dwell;
  logic        w_start;
  logic        w_abort;
  logic        w_busy;
  logic [7:0]  w_status;
  logic        w_rise;
  logic [15:0] w_target;
  logic [15:0] w_cnt_inc;
  logic        w_last;
  logic        w_timeout;
  logic        w_go;
  logic        w_abort_take;
  logic        w_advance;

  pwm_scan_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .clk       (clk),
    .res       (res),
    .addr      (bus.addr),
    .data_in   (bus.data_in),
    .we        (bus.we),
    .busy      (w_busy),
    .status    (w_status),
    .data_out  (bus.data_out),
    .zero      (w_zero),
    .sig_start (w_sig_start),
    .step      (w_step),
    .n_steps   (w_n_steps),
    .dwell     (w_dwell),
    .start     (w_start),
    .abort     (w_abort)
  );

  assign w_busy    = (r_state != IDLE);
  assign w_rise    = r_pwm_s1 & ~r_pwm_s2;
  assign w_target  = (w_dwell == 16'd0) ? 16'd1 : w_dwell;
  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_last    = ((r_idx + 16'd1) == w_n_steps);

  always_comb begin
    w_status             = 8'h00;
    w_status[c_st_busy]  = w_busy;
    w_status[c_st_done]  = r_done_flag;
    w_status[c_st_abort] = r_aborted;
    w_status[c_st_err]   = r_err;
  end

`ifdef PWM_SCAN_TIMEOUT_EN
  logic [31:0] r_wdog;

  // Held at zero outside DWELL, so every DWELL entry starts a fresh count.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_wdog <= 32'd0;
    end else if (r_state != DWELL || w_rise) begin
      r_wdog <= 32'd0;
    end else begin
      r_wdog <= r_wdog + 32'd1;
    end
  end

  assign w_timeout = (r_state == DWELL) && !w_rise && ((r_wdog + 32'd1) == TIMEOUT_CYCLES);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 32'd0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_go           = 1'b0;
    w_abort_take   = 1'b0;
    w_advance      = 1'b0;
    bus_own        = 1'b0;
    step_strb      = 1'b0;
    done           = 1'b0;
    bus.pwm_addr   = 8'h00;
    bus.pwm_data   = 8'h00;
    bus.pwm_we     = 1'b0;
    bus.pwm_data32 = 32'd0;
    bus.pwm_we32   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_go        = 1'b1;
          w_state_nxt = (w_n_steps == 16'd0) ? FIN : ZERO;
        end
      end
      ZERO: begin
        bus_own        = 1'b1;
        bus.pwm_we32   = 1'b1;
        bus.pwm_addr   = PWM_ZERO32_ADDR;
        bus.pwm_data32 = w_zero;
        w_abort_take   = w_abort;
        w_state_nxt    = (r_abort_pend || w_abort) ? STOP : SIG;
      end
      SIG: begin
        bus_own      = 1'b1;
        bus.pwm_we   = 1'b1;
        bus.pwm_addr = PWM_SIG_ADDR + {6'd0, r_byte};
        bus.pwm_data = r_cur_sig[{r_byte, 3'b000} +: 8];
        w_abort_take = w_abort;
        if (r_byte == 2'd3) begin
          w_state_nxt = (r_abort_pend || w_abort) ? STOP : DWELL;
        end
      end
      DWELL: begin
        bus_own = 1'b1;
        if (w_abort) begin
          w_abort_take = 1'b1;
          w_state_nxt  = STOP;
        end else if (w_rise && (w_cnt_inc == w_target)) begin
          w_state_nxt = NEXT;
        end else if (w_timeout) begin
          w_state_nxt = STOP;
        end
      end
      NEXT: begin
        bus_own = 1'b1;
        if (w_abort) begin
          w_abort_take = 1'b1;
          w_state_nxt  = STOP;
        end else begin
          step_strb   = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = w_last ? STOP : SIG;
        end
      end
      STOP: begin
        bus_own      = 1'b1;
        bus.pwm_we   = 1'b1;
        bus.pwm_addr = PWM_SIG_ADDR + {6'd0, r_byte};
        bus.pwm_data = 8'h00;
        if (r_byte == 2'd3) begin
          w_state_nxt = FIN;
        end
      end
      FIN: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_byte       <= 2'd0;
      r_idx        <= 16'd0;
      r_cnt        <= 16'd0;
      r_cur_sig    <= 32'd0;
      r_pwm_s1     <= 1'b0;
      r_pwm_s2     <= 1'b0;
      r_abort_pend <= 1'b0;
      r_done_flag  <= 1'b0;
      r_aborted    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_pwm_s1 <= pwm_out;
      r_pwm_s2 <= r_pwm_s1;
      // Byte index wraps 3->0 on its own, so SIG->STOP restarts at byte 0.
      r_byte   <= (r_state == SIG || r_state == STOP) ? r_byte + 2'd1 : 2'd0;
      if (r_state != DWELL) begin
        r_cnt <= 16'd0;
      end else if (w_rise) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_go) begin
        r_cur_sig    <= w_sig_start;
        r_idx        <= 16'd0;
        r_abort_pend <= 1'b0;
        r_done_flag  <= 1'b0;
        r_aborted    <= 1'b0;
        r_err        <= 1'b0;
      end
      if (w_abort_take) begin
        r_aborted    <= 1'b1;
        r_abort_pend <= 1'b1;
      end
      if (w_advance) begin
        r_idx <= r_idx + 16'd1;
        if (!w_last) begin
          r_cur_sig <= sat_add(r_cur_sig, w_step);
        end
      end
      if (r_state == FIN) begin
        r_done_flag <= 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pwm_scan_ctrl : directed vectors and scan sequences           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_pwm_scan_ctrl;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic res;
  logic pwm_out;
  logic pwm_en;
  logic bus_own;
  logic step_strb;
  logic done;

  int checks   = 0;
  int failures = 0;
  int ph       = 0;

  wr_t         wr_q  [$];
  logic [31:0] w32_q [$];
  logic [7:0]  a32_q [$];
  logic [31:0] exp_w [$];
  int step_cnt  = 0;
  int done_cnt  = 0;
  int own_cnt   = 0;
  int dwell_cyc = 0;
  int wr_base, w32_base, step_base, done_base, own_base, dwell_base;

  vec_t       vecs [8];
  logic [7:0] rd;

  pwm_scan_if bus ();

  pwm_scan_ctrl #(
    .BASE_ADDR       (8'h50),
    .PWM_SIG_ADDR    (8'h42),
    .PWM_ZERO32_ADDR (8'h46),
    .TIMEOUT_CYCLES  (32'd100)
  ) dut (
    .clk       (clk),
    .res       (res),
    .bus       (bus.slave),
    .pwm_out   (pwm_out),
    .bus_own   (bus_own),
    .step_strb (step_strb),
    .done      (done)
  );

  always #5 clk = ~clk;

  // pwm model: 2 cycles high, 3 low while enabled
  initial begin
    pwm_out = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (pwm_en) begin
        ph      = (ph == 4) ? 0 : ph + 1;
        pwm_out = (ph < 2);
      end else begin
        ph      = 0;
        pwm_out = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.pwm_we) wr_q.push_back({bus.pwm_addr, bus.pwm_data});
    if (bus.pwm_we32) begin
      w32_q.push_back(bus.pwm_data32);
      a32_q.push_back(bus.pwm_addr);
    end
    if (step_strb) step_cnt++;
    if (done) done_cnt++;
    if (bus_own) own_cnt++;
    if (bus_own && !bus.pwm_we && !bus.pwm_we32 && !step_strb) dwell_cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk);
    #2;
    bus.addr    = a;
    bus.data_in = d;
    bus.we      = 1'b1;
    @(posedge clk);
    #2;
    bus.we = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    @(posedge clk);
    #2;
    bus.addr = a;
    bus.we   = 1'b0;
    @(posedge clk);
    #2;
    d = bus.data_out;
  endtask

  task automatic configure(input logic [31:0] z, input logic [31:0] s,
                           input logic [15:0] st, input logic [15:0] n, input logic [15:0] dw);
    for (int i = 0; i < 4; i++) host_write(8'h51 + 8'(i), z[8*i +: 8]);
    for (int i = 0; i < 4; i++) host_write(8'h55 + 8'(i), s[8*i +: 8]);
    for (int i = 0; i < 2; i++) host_write(8'h59 + 8'(i), st[8*i +: 8]);
    for (int i = 0; i < 2; i++) host_write(8'h5B + 8'(i), n[8*i +: 8]);
    for (int i = 0; i < 2; i++) host_write(8'h5D + 8'(i), dw[8*i +: 8]);
  endtask

  task automatic mark();
    wr_base    = wr_q.size();
    w32_base   = w32_q.size();
    step_base  = step_cnt;
    done_base  = done_cnt;
    own_base   = own_cnt;
    dwell_base = dwell_cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt <= done_base && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (done_cnt <= done_base) begin
      checks++;
      failures++;
      $display("FAIL %s_done_wait: no done within %0d cycles", tag, budget);
    end
  endtask

  task automatic check_words(input string tag);
    logic [31:0] word;
    logic        addr_ok;
    check({tag, "_nwr"}, 32'(wr_q.size() - wr_base), 32'(4 * exp_w.size()));
    for (int w = 0; w < exp_w.size(); w++) begin
      if (wr_base + 4 * w + 3 < wr_q.size()) begin
        addr_ok = 1'b1;
        word    = 32'd0;
        for (int b = 0; b < 4; b++) begin
          word[8*b +: 8] = wr_q[wr_base + 4*w + b].d;
          if (wr_q[wr_base + 4*w + b].a != 8'h42 + 8'(b)) addr_ok = 1'b0;
        end
        check($sformatf("%s_word%0d", tag, w), word, exp_w[w]);
        check($sformatf("%s_addr%0d", tag, w), {31'd0, addr_ok}, 32'd1);
      end
    end
  endtask

  initial begin
    res         = 1'b1;
    pwm_en      = 1'b0;
    bus.addr    = 8'h00;
    bus.data_in = 8'h00;
    bus.we      = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_bus_own", {31'd0, bus_own}, 32'd0);
    check("rst_pwm_we", {31'd0, bus.pwm_we}, 32'd0);
    check("rst_pwm_we32", {31'd0, bus.pwm_we32}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_step_strb", {31'd0, step_strb}, 32'd0);
    check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    res = 1'b0;

    // register readback, ctrl/status/out-of-window behaviour
    vecs[0] = '{8'h51, 8'h88, 8'h88};
    vecs[1] = '{8'h58, 8'hA5, 8'hA5};
    vecs[2] = '{8'h5D, 8'h07, 8'h07};
    vecs[3] = '{8'h5A, 8'h3C, 8'h3C};
    vecs[4] = '{8'h50, 8'h00, 8'h00};
    vecs[5] = '{8'h4F, 8'h12, 8'h00};
    vecs[6] = '{8'h60, 8'h34, 8'h00};
    vecs[7] = '{8'h5F, 8'hFF, 8'h00};
    for (int i = 0; i < 8; i++) begin
      host_write(vecs[i].addr, vecs[i].wdata);
      host_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_rd_%0h", i, vecs[i].addr), {24'd0, rd}, {24'd0, vecs[i].exp});
    end

    // basic three-step scan
    pwm_en = 1'b1;
    configure(32'd5000, 32'd2, 16'd2, 16'd3, 16'd2);
    mark();
    host_write(8'h50, 8'h01);
    wait_done(500, "t1");
    check("t1_n_we32", 32'(w32_q.size() - w32_base), 32'd1);
    if (w32_q.size() > w32_base) begin
      check("t1_zero_data", w32_q[w32_base], 32'd5000);
      check("t1_zero_addr", {24'd0, a32_q[w32_base]}, 32'h46);
    end
    exp_w = '{32'd2, 32'd4, 32'd6, 32'd0};
    check_words("t1");
    check("t1_steps", 32'(step_cnt - step_base), 32'd3);
    check("t1_dones", 32'(done_cnt - done_base), 32'd1);
    host_read(8'h5F, rd);
    check("t1_status", {24'd0, rd}, 32'h02);

    // zero steps: straight to FIN
    configure(32'd7, 32'd9, 16'd1, 16'd0, 16'd0);
    mark();
    host_write(8'h50, 8'h01);
    check("t2_done_early", {31'd0, done}, 32'd0);
    @(posedge clk);
    #2;
    check("t2_done_2cyc", {31'd0, done}, 32'd1);
    @(posedge clk);
    #2;
    check("t2_dones", 32'(done_cnt - done_base), 32'd1);
    check("t2_no_we", 32'(wr_q.size() - wr_base), 32'd0);
    check("t2_no_we32", 32'(w32_q.size() - w32_base), 32'd0);
    check("t2_no_own", 32'(own_cnt - own_base), 32'd0);
    host_read(8'h5F, rd);
    check("t2_status", {24'd0, rd}, 32'h02);

    // abort during DWELL of the second step
    configure(32'd1000, 32'd10, 16'd10, 16'd5, 16'd3);
    mark();
    host_write(8'h50, 8'h01);
    for (int n = 0; n < 200; n++) begin
      if (wr_q.size() - wr_base == 8 && bus_own && !bus.pwm_we) break;
      @(posedge clk);
      #2;
    end
    check("t3_reach_dwell2", {31'd0, (wr_q.size() - wr_base == 8) && bus_own && !bus.pwm_we}, 32'd1);
    host_write(8'h50, 8'h02);
    wait_done(200, "t3");
    exp_w = '{32'd10, 32'd20, 32'd0};
    check_words("t3");
    check("t3_steps", 32'(step_cnt - step_base), 32'd1);
    host_read(8'h5F, rd);
    check("t3_status", {24'd0, rd}, 32'h06);

    // saturation of the pulse width
    configure(32'd0, 32'hFFFF_FFFE, 16'd4, 16'd2, 16'd1);
    mark();
    host_write(8'h50, 8'h01);
    wait_done(300, "t4");
    exp_w = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};
    check_words("t4");
    check("t4_steps", 32'(step_cnt - step_base), 32'd2);
    host_read(8'h5F, rd);
    check("t4_status", {24'd0, rd}, 32'h02);

    // pwm stalled in DWELL
    pwm_en = 1'b0;
    repeat (4) @(posedge clk);
    configure(32'd50, 32'h0000_00AB, 16'd1, 16'd2, 16'd1);
    mark();
    host_write(8'h50, 8'h01);
`ifdef PWM_SCAN_TIMEOUT_EN
    wait_done(400, "t6");
    check("t6_dwell_cycles", 32'(dwell_cyc - dwell_base), 32'd100);
    check("t6_steps", 32'(step_cnt - step_base), 32'd0);
    exp_w = '{32'h0000_00AB, 32'd0};
    check_words("t6");
    host_read(8'h5F, rd);
    check("t6_status", {24'd0, rd}, 32'h0A);
`else
    repeat (150) @(posedge clk);
    #2;
    check("t6_no_done", 32'(done_cnt - done_base), 32'd0);
    host_read(8'h5F, rd);
    check("t6_status_busy", {24'd0, rd}, 32'h01);
    host_write(8'h50, 8'h02);
    wait_done(100, "t6");
    exp_w = '{32'h0000_00AB, 32'd0};
    check_words("t6");
    host_read(8'h5F, rd);
    check("t6_status", {24'd0, rd}, 32'h06);
`endif

    // asynchronous reset in the second SIG cycle
    pwm_en = 1'b1;
    configure(32'd100, 32'h1234_5678, 16'd1, 16'd3, 16'd1);
    host_write(8'h50, 8'h01);
    for (int n = 0; n < 50; n++) begin
      if (bus.pwm_we && bus.pwm_addr == 8'h43) break;
      @(posedge clk);
      #2;
    end
    check("t5_reach_sig1", {31'd0, bus.pwm_we && (bus.pwm_addr == 8'h43)}, 32'd1);
    #1;
    res = 1'b1;
    #1;
    check("t5_pwm_we", {31'd0, bus.pwm_we}, 32'd0);
    check("t5_bus_own", {31'd0, bus_own}, 32'd0);
    check("t5_data_out", {24'd0, bus.data_out}, 32'd0);
    @(posedge clk);
    #2;
    res = 1'b0;
    mark();
    host_read(8'h5F, rd);
    check("t5_status", {24'd0, rd}, 32'h00);
    host_read(8'h55, rd);
    check("t5_sig_start0", {24'd0, rd}, 32'h00);
    host_read(8'h5B, rd);
    check("t5_n_steps0", {24'd0, rd}, 32'h00);
    repeat (20) @(posedge clk);
    #2;
    check("t5_idle_no_we", 32'(wr_q.size() - wr_base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
